l2_block_mem: RTL and testbench

- Block-granular backing memory (L2 / main-memory model) sitting directly downstream of the L1 cache's miss-fetch port.
- Serves one block-sized read or write per request with a programmable fixed latency.
- Signals completion through the cache's `mem_miss` handshake: high while busy, low when done.
- Single-ported: one address per request; `mem_we` selects write-back vs fill.

---
 rtl/l2_mem_pkg.sv | 12 +
 rtl/l2_latency_ctr.sv | 21 ++
 rtl/l2_block_mem.sv | 129 ++++++++++++
 tb/tb_l2_block_mem.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg: shared block type, FSM states and width helpers for the L2 block memory
package l2_mem_pkg;
   localparam int L2_BLOCKS = 4;
   typedef logic [L2_BLOCKS-1:0][31:0] mem_block_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   function automatic int index_w(input int ram_size, input int blocks);
      return $clog2(ram_size / (blocks * 4));
   endfunction
   function automatic int cnt_w(input int latency);
      return $clog2(latency) + 1;
   endfunction
endpackage

// File: rtl/l2_latency_ctr.sv
// l2_latency_ctr: loadable down-counter with clear, counts toward zero while enabled
module l2_latency_ctr #(
   parameter int W = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_load,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;
   // Clear beats load; decrement stops at zero
   always_ff @(posedge clock or negedge reset)
      if (!reset) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_load) r_cnt <= i_val;
      else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_zero = r_cnt == '0;
endmodule

// File: rtl/l2_block_mem.sv
// l2_block_mem: fixed-latency block-granular backing memory; L2_MEM_PERF_EN adds perf counters
module l2_block_mem
   import l2_mem_pkg::*;
#(
   parameter int BLOCKS   = L2_BLOCKS,
   parameter int RAM_SIZE = 65536,
   parameter int LATENCY  = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   mem_req,
   input  logic                   mem_we,
   input  logic [31:0]            mem_addr,
   input  logic [BLOCKS*32-1:0]   mem_write_block,
   output logic [BLOCKS*32-1:0]   mem_read_block,
   output logic                   mem_miss
`ifdef L2_MEM_PERF_EN
   ,
   output logic [31:0]            perf_reads,
   output logic [31:0]            perf_writes,
   output logic [31:0]            perf_busy_cycles
`endif
);
   localparam int INDEX_W = index_w(RAM_SIZE, BLOCKS);
   localparam int CNT_W   = cnt_w(LATENCY);
   localparam int LSB     = $clog2(BLOCKS) + 2;
   localparam int MSB     = $clog2(RAM_SIZE) - 1;
   localparam int DEPTH   = RAM_SIZE / (BLOCKS * 4);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

   state_t                r_state, w_next;
   logic [INDEX_W-1:0]    r_idx, w_in_idx, w_a_idx;
   logic                  r_we, w_a_we;
   logic [BLOCKS*32-1:0]  r_wdata, w_a_data, r_rdata;
   logic [BLOCKS*32-1:0]  r_mem [DEPTH];
   logic                  w_miss, w_access, w_load, w_clr, w_zero, w_unused;

   assign w_in_idx = mem_addr[MSB:LSB];
   assign w_unused = ^{mem_addr[31:MSB+1], mem_addr[LSB-1:0]};
   // Single-cycle latency accesses straight from the request; otherwise from the captured copy
   assign w_a_idx  = LATENCY == 1 ? w_in_idx : r_idx;
   assign w_a_we   = LATENCY == 1 ? mem_we : r_we;
   assign w_a_data = LATENCY == 1 ? mem_write_block : r_wdata;
   assign mem_miss = reset & w_miss;
   assign mem_read_block = r_rdata;

   l2_latency_ctr #(.W(CNT_W)) u_ctr (
      .clock  (clock),
      .reset  (reset),
      .i_load (w_load),
      .i_clr  (w_clr),
      .i_en   (r_state == BUSY),
      .i_val  (LOAD_VAL),
      .o_zero (w_zero)
   );

   // Next state, handshake and access strobe; dropping the request in BUSY aborts
   always_comb begin
      w_next   = r_state;
      w_miss   = 1'b0;
      w_access = 1'b0;
      w_load   = 1'b0;
      w_clr    = 1'b0;
      case (r_state)
         IDLE: begin
            w_miss = mem_req;
            if (mem_req) begin
               w_next   = LATENCY == 1 ? DONE : BUSY;
               w_load   = LATENCY > 1;
               w_access = LATENCY == 1;
            end
         end
         BUSY: begin
            w_miss = 1'b1;
            if (!mem_req) begin
               w_next = IDLE;
               w_clr  = 1'b1;
            end else if (w_zero) begin
               w_next   = DONE;
               w_access = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State register and capture of the request on acceptance
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && mem_req) begin
            r_idx   <= w_in_idx;
            r_we    <= mem_we;
            r_wdata <= mem_write_block;
         end
      end

   // Read data register only changes when a fill completes
   always_ff @(posedge clock or negedge reset)
      if (!reset) r_rdata <= '0;
      else if (w_access && !w_a_we) r_rdata <= r_mem[w_a_idx];

   // Storage array is never cleared; writes are suppressed while reset is held
   always_ff @(posedge clock)
      if (reset && w_access && w_a_we) r_mem[w_a_idx] <= w_a_data;

`ifdef L2_MEM_PERF_EN
   logic [31:0] r_perf_reads, r_perf_writes, r_perf_busy;
   // Saturating event counters; aborted requests only accumulate busy cycles
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         r_perf_reads  <= '0;
         r_perf_writes <= '0;
         r_perf_busy   <= '0;
      end else begin
         if (w_access && !w_a_we && r_perf_reads != '1) r_perf_reads <= r_perf_reads + 1'b1;
         if (w_access && w_a_we && r_perf_writes != '1) r_perf_writes <= r_perf_writes + 1'b1;
         if (mem_miss && r_perf_busy != '1) r_perf_busy <= r_perf_busy + 1'b1;
      end
   assign perf_reads       = r_perf_reads;
   assign perf_writes      = r_perf_writes;
   assign perf_busy_cycles = r_perf_busy;
`endif
endmodule

// File: tb/tb_l2_block_mem.sv
// tb_l2_block_mem: directed self-checking bench for l2_block_mem (LATENCY 4 and LATENCY 1 instances)
module tb_l2_block_mem;
   localparam logic [127:0] B1234 = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [127:0] BABCD = {32'hD, 32'hC, 32'hB, 32'hA};
   localparam logic [127:0] BV    = {32'h1111_0004, 32'h1111_0003, 32'h1111_0002, 32'h1111_0001};
   localparam logic [127:0] BW    = {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001};
   localparam logic [127:0] BZ    = {4{32'hDEAD_BEEF}};
   localparam logic [127:0] BP    = {32'h5000_0004, 32'h5000_0003, 32'h5000_0002, 32'h5000_0001};
   localparam logic [127:0] BQ    = {32'h6000_0004, 32'h6000_0003, 32'h6000_0002, 32'h6000_0001};

   logic clock = 1'b0;
   logic reset;
   logic req, we, miss, req1, we1, miss1;
   logic [31:0] addr, addr1;
   logic [127:0] wblk, rblk, wblk1, rblk1;
   int checks = 0;
   int errors = 0;
`ifdef L2_MEM_PERF_EN
   logic [31:0] p_rd, p_wr, p_busy, p1_rd, p1_wr, p1_busy;
`endif

   always #5 clock = ~clock;

   l2_block_mem #(.BLOCKS(4), .RAM_SIZE(65536), .LATENCY(4)) u_dut (
      .clock           (clock),
      .reset           (reset),
      .mem_req         (req),
      .mem_we          (we),
      .mem_addr        (addr),
      .mem_write_block (wblk),
      .mem_read_block  (rblk),
      .mem_miss        (miss)
`ifdef L2_MEM_PERF_EN
      ,
      .perf_reads       (p_rd),
      .perf_writes      (p_wr),
      .perf_busy_cycles (p_busy)
`endif
   );

   l2_block_mem #(.BLOCKS(4), .RAM_SIZE(65536), .LATENCY(1)) u_dut1 (
      .clock           (clock),
      .reset           (reset),
      .mem_req         (req1),
      .mem_we          (we1),
      .mem_addr        (addr1),
      .mem_write_block (wblk1),
      .mem_read_block  (rblk1),
      .mem_miss        (miss1)
`ifdef L2_MEM_PERF_EN
      ,
      .perf_reads       (p1_rd),
      .perf_writes      (p1_wr),
      .perf_busy_cycles (p1_busy)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_req(input logic w, input logic [31:0] a, input logic [127:0] d,
                          output int cyc, output logic [127:0] rd);
      req = 1'b1; we = w; addr = a; wblk = d; cyc = 0;
      @(negedge clock);
      while (miss && cyc < 20) begin
         cyc++;
         @(negedge clock);
      end
      rd = rblk;
      @(posedge clock); #1;
      req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [127:0] rd;
      reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wblk = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wblk1 = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_miss", 128'(miss), 128'd0);
      chk("rst_rblk", rblk, 128'd0);
      chk("rst_miss1", 128'(miss1), 128'd0);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1;
      run_req(1'b1, 32'h40, B1234, cyc, rd);
      chk("preload_lat", 128'(cyc), 128'd4);
      chk("preload_rblk_keep", rd, 128'd0);
      // read of word 2 in block 0x40, miss high cycles 0..3
      req = 1'b1; we = 1'b0; addr = 32'h48;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock); chk("rd_miss_busy", 128'(miss), 128'd1);
         @(posedge clock); #1;
      end
      @(negedge clock);
      chk("rd_done_miss", 128'(miss), 128'd0);
      chk("rd_done_data", rblk, B1234);
      // write-back then fill with req held high
      @(posedge clock); #1;
      we = 1'b1; addr = 32'h100; wblk = BABCD;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock); chk("wb_miss_busy", 128'(miss), 128'd1);
         @(posedge clock); #1;
      end
      @(negedge clock);
      chk("wb_done_miss", 128'(miss), 128'd0);
      chk("wb_rblk_keep", rblk, B1234);
      @(posedge clock); #1;
      we = 1'b0; addr = 32'h10C;
      for (int c = 5; c < 9; c++) begin
         @(negedge clock); chk("fill_miss_busy", 128'(miss), 128'd1);
         @(posedge clock); #1;
         if (c == 5) addr = 32'h40;
      end
      @(negedge clock);
      chk("fill_done_miss", 128'(miss), 128'd0);
      chk("fill_data_latched_addr", rblk, BABCD);
      @(posedge clock); #1 req = 1'b0;
      @(negedge clock);
      chk("idle_miss", 128'(miss), 128'd0);
      chk("idle_rblk_hold", rblk, BABCD);
      // LATENCY=1 instance
      @(posedge clock); #1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wblk1 = BV;
      @(negedge clock); chk("l1_wr_miss", 128'(miss1), 128'd1);
      @(posedge clock); #1;
      @(negedge clock); chk("l1_wr_done", 128'(miss1), 128'd0);
      @(posedge clock); #1 we1 = 1'b0;
      @(negedge clock); chk("l1_rd_miss", 128'(miss1), 128'd1);
      @(posedge clock); #1;
      @(negedge clock);
      chk("l1_rd_done", 128'(miss1), 128'd0);
      chk("l1_rd_data", rblk1, BV);
      @(posedge clock); #1 req1 = 1'b0;
      // wrap-around modulo RAM_SIZE
      run_req(1'b1, 32'h0001_0100, BW, cyc, rd);
      run_req(1'b0, 32'h0000_0100, '0, cyc, rd);
      chk("wrap_lat", 128'(cyc), 128'd4);
      chk("wrap_data", rd, BW);
      // abort a write at cycle 2
      req = 1'b1; we = 1'b1; addr = 32'h40; wblk = BZ;
      @(negedge clock); @(posedge clock); #1;
      @(negedge clock); @(posedge clock); #1 req = 1'b0;
      @(negedge clock); chk("abort_busy_miss", 128'(miss), 128'd1);
      @(posedge clock); #1;
      @(negedge clock); chk("abort_idle_miss", 128'(miss), 128'd0);
      @(posedge clock); #1;
      run_req(1'b0, 32'h40, '0, cyc, rd);
      chk("abort_no_write", rd, B1234);
      // reset in the middle of a write
      req = 1'b1; we = 1'b1; addr = 32'h40; wblk = BZ;
      @(negedge clock); @(posedge clock); #1;
      @(negedge clock); @(posedge clock); #1 reset = 1'b0;
      #1;
      chk("rst_busy_miss", 128'(miss), 128'd0);
      chk("rst_busy_rblk", rblk, 128'd0);
      @(posedge clock); #1 req = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      @(negedge clock); chk("rst_release_miss", 128'(miss), 128'd0);
      @(posedge clock); #1;
      // 2 writes + 3 reads after reset
      run_req(1'b1, 32'h200, BP, cyc, rd);
      chk("p_wr0_lat", 128'(cyc), 128'd4);
      run_req(1'b1, 32'h240, BQ, cyc, rd);
      run_req(1'b0, 32'h204, '0, cyc, rd);
      chk("p_rd0", rd, BP);
      run_req(1'b0, 32'h248, '0, cyc, rd);
      chk("p_rd1", rd, BQ);
      run_req(1'b0, 32'h40, '0, cyc, rd);
      chk("rst_no_write", rd, B1234);
      chk("p_rd2_lat", 128'(cyc), 128'd4);
`ifdef L2_MEM_PERF_EN
      chk("perf_reads", 128'(p_rd), 128'd3);
      chk("perf_writes", 128'(p_wr), 128'd2);
      chk("perf_busy", 128'(p_busy), 128'd20);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
